hdlc_rx_frame_ctrl: RTL and testbench
=====================================

# hdlc_rx_frame_ctrl

Receive-side frame controller for the HDLC core. It sequences the Rx datapath: it opens a frame on a flag, gates byte writes into the Rx buffer, and counts frame length. It also turns abort, overflow and FCS events into status, and holds a completed frame until the CPU-side register block acknowledges it. It sits between the flag/abort detectors and byte assembler (inputs) and the Rx buffer and status registers (outputs).

## Interface
- MAX_BYTES, 128: Rx buffer depth in bytes; byte MAX_BYTES+1 of a frame causes overflow.
- MIN_BYTES, 4: minimum received bytes (2 FCS included) for a frame to be error-free.
- SIZE_W, 8: width of Rx_FrameSize; must hold MAX_BYTES.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- RxEN  in  1  receiver enable.
- Rx_FlagDetect  in  1  one-cycle pulse: flag 01111110 detected.
- Rx_AbortDetect  in  1  one-cycle pulse: abort pattern (7+ ones) detected.
- Rx_NewByte  in  1  one-cycle pulse: de-stuffed byte available from assembler.
- Rx_FCSerr  in  1  FCS check result, valid in the cycle of the closing Rx_FlagDetect.
- Rx_Ack  in  1  one-cycle pulse from register block: frame read or dropped.
- Rx_ValidFrame  out  1  high while a frame is open with at least one byte.
- Rx_WrBuff  out  1  one-cycle write strobe to Rx buffer.
- Rx_AbortSignal  out  1  one-cycle pulse: open frame aborted.
- Rx_Overflow  out  1  sticky: frame exceeded MAX_BYTES.
- Rx_EoF  out  1  one-cycle pulse: frame closed.
- Rx_Ready  out  1  completed frame held for CPU.
- Rx_FrameError  out  1  completed frame is bad (short, FCS error or overflow).
- Rx_FrameSize  out  SIZE_W  data bytes of completed frame, FCS excluded.

## Operation
- States: IDLE (hunt for flag), OPEN (flag seen, no data), FRAME (receiving), HOLD (frame waiting for Rx_Ack).
- Reset: state IDLE; every output 0; byte counter 0.
- IDLE: Rx_FlagDetect && RxEN goes to OPEN. All other inputs are ignored.
- OPEN:
  - Rx_NewByte goes to FRAME, count=1, Rx_WrBuff, Rx_ValidFrame=1, Rx_Overflow cleared.
  - Rx_FlagDetect stays in OPEN (idle flags).
  - Rx_AbortDetect goes to IDLE with no Rx_AbortSignal.
- FRAME:
  - Rx_NewByte with count<MAX_BYTES: count+1 and Rx_WrBuff.
  - Rx_NewByte with count==MAX_BYTES: Rx_Overflow=1, no write, count holds.
  - Rx_FlagDetect: close frame, go to HOLD, Rx_EoF, Rx_ValidFrame=0, Rx_Ready=1.
    - Rx_FrameError = Rx_Overflow | Rx_FCSerr | (count<MIN_BYTES).
    - Rx_FrameSize = count-2, saturating at 0.
  - Rx_AbortDetect: Rx_AbortSignal, Rx_ValidFrame=0, go to IDLE. No Rx_EoF and no Rx_Ready.
- HOLD:
  - All Rx inputs are ignored and nothing is written.
  - Rx_Ack clears Rx_Ready, Rx_FrameError, Rx_FrameSize and Rx_Overflow, then goes to IDLE.
- Priority in one cycle: Rst > !RxEN > Rx_AbortDetect > Rx_FlagDetect > Rx_NewByte. When a byte coincides with a flag or abort, the byte is dropped.
- RxEN low in OPEN or FRAME: go to IDLE, Rx_ValidFrame=0, no Rx_EoF, no Rx_AbortSignal.
- RxEN low in HOLD: the held frame is kept until Rx_Ack.
- Rx_Ack outside HOLD: ignored.

## Timing
- All outputs are registered. Every response appears on the edge after the causing input cycle.
- Rx_WrBuff: one cycle after Rx_NewByte; exactly one pulse per accepted byte.
- Rx_ValidFrame: rises one cycle after the first Rx_NewByte; falls one cycle after the closing flag or abort.
- Rx_AbortSignal: one cycle after Rx_AbortDetect when Rx_ValidFrame=1 (Rx_AbortDetect && Rx_ValidFrame |=> Rx_AbortSignal); one cycle wide.
- Rx_EoF: one cycle after the closing flag; one cycle wide.
  - Rx_Ready, Rx_FrameError and Rx_FrameSize are valid in the same cycle as Rx_EoF and stable until one cycle after Rx_Ack.
- Rx_Overflow: rises one cycle after byte MAX_BYTES+1; held until Rx_Ack or the next frame's first byte.
- Back-to-back inputs: Rx_NewByte in consecutive cycles must be accepted. No input needs more than one cycle of spacing.

## Test plan
- Flag, 6 NewBytes, flag (FCSerr=0): 6 WrBuff pulses, EoF one cycle after the flag, FrameSize=4, FrameError=0, Ready=1; Ack gives Ready=0 one cycle later.
- Flag, 3 NewBytes, AbortDetect: AbortSignal pulse one cycle later, ValidFrame=0, no EoF, Ready=0, state IDLE; the next frame is received normally.
- Flag, 130 NewBytes, flag: exactly 128 WrBuff pulses, Overflow=1 after byte 129, FrameSize=126, FrameError=1.
- Flag, 2 NewBytes, flag: FrameSize=0 and FrameError=1. Separately, 6 bytes with FCSerr=1 at the closing flag: FrameError=1 and FrameSize=4.
- Repeated flags with no data, then AbortDetect in OPEN: no ValidFrame, no AbortSignal, no EoF. NewByte and FlagDetect in the same cycle in FRAME: no WrBuff for that byte and EoF follows.
- RxEN dropped mid-frame: ValidFrame falls next cycle with no EoF or AbortSignal. Rst asserted in HOLD: all outputs 0 on the next edge. Frames arriving during HOLD produce no WrBuff.

Source files
------------

// File: rtl/hdlc_rx_frame_ctrl.sv
// hdlc_rx_frame_ctrl
// Receive-side frame controller for the HDLC core. It opens a frame on a
// flag and gates de-stuffed bytes into the Rx buffer. It counts the frame
// length, turns abort/overflow/FCS events into status, and holds a
// completed frame until the register block acknowledges it.
//
// Ports:
//   Clk, Rst          clock (rising edge) and synchronous active-high reset
//   RxEN              receiver enable
//   Rx_FlagDetect     one-cycle pulse, flag seen
//   Rx_AbortDetect    one-cycle pulse, abort pattern seen
//   Rx_NewByte        one-cycle pulse, byte available from assembler
//   Rx_FCSerr         FCS result, valid with the closing flag
//   Rx_Ack            one-cycle pulse, held frame consumed
//   Rx_ValidFrame     frame open with at least one byte
//   Rx_WrBuff         one-cycle write strobe into the Rx buffer
//   Rx_AbortSignal    one-cycle pulse, open frame aborted
//   Rx_Overflow       sticky, frame exceeded MAX_BYTES
//   Rx_EoF            one-cycle pulse, frame closed
//   Rx_Ready          completed frame held for the CPU
//   Rx_FrameError     held frame is short, has an FCS error or overflowed
//   Rx_FrameSize      data bytes of the held frame, FCS excluded
module hdlc_rx_frame_ctrl #(
    parameter int MAX_BYTES = 128,
    parameter int MIN_BYTES = 4,
    parameter int SIZE_W    = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              RxEN,
    input  logic              Rx_FlagDetect,
    input  logic              Rx_AbortDetect,
    input  logic              Rx_NewByte,
    input  logic              Rx_FCSerr,
    input  logic              Rx_Ack,
    output logic              Rx_ValidFrame,
    output logic              Rx_WrBuff,
    output logic              Rx_AbortSignal,
    output logic              Rx_Overflow,
    output logic              Rx_EoF,
    output logic              Rx_Ready,
    output logic              Rx_FrameError,
    output logic [SIZE_W-1:0] Rx_FrameSize
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        FRAME,
        HOLD
    } state_t;

    localparam logic [SIZE_W-1:0] MAX_CNT = SIZE_W'(MAX_BYTES);
    localparam logic [SIZE_W-1:0] MIN_CNT = SIZE_W'(MIN_BYTES);
    localparam logic [SIZE_W-1:0] FCS_LEN = SIZE_W'(2);

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] count_q, count_d;
    logic              valid_frame_q, valid_frame_d;
    logic              wr_buff_q, wr_buff_d;
    logic              abort_signal_q, abort_signal_d;
    logic              overflow_q, overflow_d;
    logic              eof_q, eof_d;
    logic              ready_q, ready_d;
    logic              frame_error_q, frame_error_d;
    logic [SIZE_W-1:0] frame_size_q, frame_size_d;

    // State register and all registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            valid_frame_q  <= 1'b0;
            wr_buff_q      <= 1'b0;
            abort_signal_q <= 1'b0;
            overflow_q     <= 1'b0;
            eof_q          <= 1'b0;
            ready_q        <= 1'b0;
            frame_error_q  <= 1'b0;
            frame_size_q   <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            valid_frame_q  <= valid_frame_d;
            wr_buff_q      <= wr_buff_d;
            abort_signal_q <= abort_signal_d;
            overflow_q     <= overflow_d;
            eof_q          <= eof_d;
            ready_q        <= ready_d;
            frame_error_q  <= frame_error_d;
            frame_size_q   <= frame_size_d;
        end
    end

    // Next-state and output logic. The if/else order inside each state
    // encodes the priority !RxEN > abort > flag > byte, so a byte that
    // coincides with a flag or abort is simply dropped.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        valid_frame_d  = valid_frame_q;
        wr_buff_d      = 1'b0;
        abort_signal_d = 1'b0;
        overflow_d     = overflow_q;
        eof_d          = 1'b0;
        ready_d        = ready_q;
        frame_error_d  = frame_error_q;
        frame_size_d   = frame_size_q;

        unique case (state_q)
            IDLE: begin
                if (RxEN && !Rx_AbortDetect && Rx_FlagDetect) begin
                    state_d = OPEN;
                end
            end
            OPEN: begin
                if (!RxEN || Rx_AbortDetect) begin
                    // No data yet, so an abort here is silent.
                    state_d = IDLE;
                end else if (Rx_FlagDetect) begin
                    state_d = OPEN;
                end else if (Rx_NewByte) begin
                    state_d       = FRAME;
                    count_d       = SIZE_W'(1);
                    wr_buff_d     = 1'b1;
                    valid_frame_d = 1'b1;
                    overflow_d    = 1'b0;
                end
            end
            FRAME: begin
                if (!RxEN) begin
                    state_d       = IDLE;
                    valid_frame_d = 1'b0;
                end else if (Rx_AbortDetect) begin
                    state_d        = IDLE;
                    valid_frame_d  = 1'b0;
                    abort_signal_d = 1'b1;
                end else if (Rx_FlagDetect) begin
                    state_d       = HOLD;
                    valid_frame_d = 1'b0;
                    eof_d         = 1'b1;
                    ready_d       = 1'b1;
                    frame_error_d = overflow_q | Rx_FCSerr | (count_q < MIN_CNT);
                    // Strip the two FCS bytes, never wrapping below zero.
                    frame_size_d  = (count_q >= FCS_LEN) ? (count_q - FCS_LEN) : '0;
                end else if (Rx_NewByte) begin
                    if (count_q < MAX_CNT) begin
                        count_d   = count_q + SIZE_W'(1);
                        wr_buff_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // The held frame survives RxEN going low; only Ack frees it.
                if (Rx_Ack) begin
                    state_d       = IDLE;
                    ready_d       = 1'b0;
                    frame_error_d = 1'b0;
                    frame_size_d  = '0;
                    overflow_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Rx_ValidFrame  = valid_frame_q;
    assign Rx_WrBuff      = wr_buff_q;
    assign Rx_AbortSignal = abort_signal_q;
    assign Rx_Overflow    = overflow_q;
    assign Rx_EoF         = eof_q;
    assign Rx_Ready       = ready_q;
    assign Rx_FrameError  = frame_error_q;
    assign Rx_FrameSize   = frame_size_q;

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// tb_hdlc_rx_frame_ctrl
// Directed bench for hdlc_rx_frame_ctrl. Stimulus pushes the expected
// output events (write strobes, end-of-frame with size/error, abort pulses)
// into a queue; a monitor pops and compares whenever the DUT emits one.
module tb_hdlc_rx_frame_ctrl;

    localparam int SIZE_W = 8;

    localparam int EV_WR    = 1;
    localparam int EV_EOF   = 2;
    localparam int EV_ABORT = 3;

    typedef struct {
        int   kind;
        int   size;
        logic err;
    } exp_t;

    logic              Clk;
    logic              Rst;
    logic              RxEN;
    logic              Rx_FlagDetect;
    logic              Rx_AbortDetect;
    logic              Rx_NewByte;
    logic              Rx_FCSerr;
    logic              Rx_Ack;
    logic              Rx_ValidFrame;
    logic              Rx_WrBuff;
    logic              Rx_AbortSignal;
    logic              Rx_Overflow;
    logic              Rx_EoF;
    logic              Rx_Ready;
    logic              Rx_FrameError;
    logic [SIZE_W-1:0] Rx_FrameSize;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    hdlc_rx_frame_ctrl #(
        .MAX_BYTES(128),
        .MIN_BYTES(4),
        .SIZE_W(SIZE_W)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .RxEN(RxEN),
        .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_NewByte(Rx_NewByte),
        .Rx_FCSerr(Rx_FCSerr),
        .Rx_Ack(Rx_Ack),
        .Rx_ValidFrame(Rx_ValidFrame),
        .Rx_WrBuff(Rx_WrBuff),
        .Rx_AbortSignal(Rx_AbortSignal),
        .Rx_Overflow(Rx_Overflow),
        .Rx_EoF(Rx_EoF),
        .Rx_Ready(Rx_Ready),
        .Rx_FrameError(Rx_FrameError),
        .Rx_FrameSize(Rx_FrameSize)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one input cycle; inputs are sampled on the next rising edge and
    // the task returns 1 ns after it, once registered outputs have settled.
    task automatic applyStimulus(input logic flag, input logic abort, input logic nb,
                                 input logic fcs, input logic ack);
        Rx_FlagDetect  = flag;
        Rx_AbortDetect = abort;
        Rx_NewByte     = nb;
        Rx_FCSerr      = fcs;
        Rx_Ack         = ack;
        @(posedge Clk);
        #1;
        Rx_FlagDetect  = 1'b0;
        Rx_AbortDetect = 1'b0;
        Rx_NewByte     = 1'b0;
        Rx_FCSerr      = 1'b0;
        Rx_Ack         = 1'b0;
    endtask

    task automatic pushEvent(input int kind, input int size, input logic err);
        exp_t e;
        e.kind = kind;
        e.size = size;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic sendByte(input logic expectWrite);
        if (expectWrite) pushEvent(EV_WR, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic sendFrame(input int nBytes, input logic fcs, input int size, input logic err);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nBytes; i++) sendByte(1'b1);
        pushEvent(EV_EOF, size, err);
        applyStimulus(1'b1, 1'b0, 1'b0, fcs, 1'b0);
    endtask

    // Bounded wait for the monitor to consume every expected event.
    task automatic drainCheck(input string name);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge Clk);
        #1;
        checkOutput(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic ackAndCheck(input string name);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput({name, "_ready_cleared"}, int'(Rx_Ready), 0);
        checkOutput({name, "_err_cleared"}, int'(Rx_FrameError), 0);
        checkOutput({name, "_size_cleared"}, int'(Rx_FrameSize), 0);
        checkOutput({name, "_ovf_cleared"}, int'(Rx_Overflow), 0);
    endtask

    task automatic unexpectedEvent(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got event, expected none", name);
    endtask

    // Monitor: consumes expected events as the DUT produces them.
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst) begin
            if (Rx_WrBuff) begin
                if (exp_q.size() == 0) unexpectedEvent("wrbuff_unexpected");
                else begin
                    e = exp_q.pop_front();
                    checkOutput("wrbuff_kind", EV_WR, e.kind);
                end
            end
            if (Rx_EoF) begin
                if (exp_q.size() == 0) unexpectedEvent("eof_unexpected");
                else begin
                    e = exp_q.pop_front();
                    checkOutput("eof_kind", EV_EOF, e.kind);
                    if (e.kind == EV_EOF) begin
                        checkOutput("eof_size", int'(Rx_FrameSize), e.size);
                        checkOutput("eof_err", int'(Rx_FrameError), int'(e.err));
                        checkOutput("eof_ready", int'(Rx_Ready), 1);
                        checkOutput("eof_valid", int'(Rx_ValidFrame), 0);
                    end
                end
            end
            if (Rx_AbortSignal) begin
                if (exp_q.size() == 0) unexpectedEvent("abort_unexpected");
                else begin
                    e = exp_q.pop_front();
                    checkOutput("abort_kind", EV_ABORT, e.kind);
                    checkOutput("abort_valid", int'(Rx_ValidFrame), 0);
                end
            end
        end
    end

    initial begin
        Rst = 1'b1;
        RxEN = 1'b1;
        Rx_FlagDetect = 1'b0;
        Rx_AbortDetect = 1'b0;
        Rx_NewByte = 1'b0;
        Rx_FCSerr = 1'b0;
        Rx_Ack = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_outputs",
                    int'({Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow,
                          Rx_EoF, Rx_Ready, Rx_FrameError}), 0);
        checkOutput("reset_size", int'(Rx_FrameSize), 0);
        Rst = 1'b0;

        $display("[TB] good 6-byte frame");
        sendFrame(6, 1'b0, 4, 1'b0);
        drainCheck("good_drain");
        checkOutput("good_ready_held", int'(Rx_Ready), 1);
        checkOutput("good_size_held", int'(Rx_FrameSize), 4);
        ackAndCheck("good");

        $display("[TB] abort after 3 bytes, then a normal frame");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sendByte(1'b1);
        checkOutput("abort_valid_before", int'(Rx_ValidFrame), 1);
        pushEvent(EV_ABORT, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_valid_after", int'(Rx_ValidFrame), 0);
        checkOutput("abort_ready", int'(Rx_Ready), 0);
        drainCheck("abort_drain");
        sendFrame(5, 1'b0, 3, 1'b0);
        drainCheck("after_abort_drain");
        ackAndCheck("after_abort");

        $display("[TB] 130-byte overflow frame");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 130; i++) begin
            sendByte(i <= 128);
            if (i == 128) checkOutput("ovf_at_128", int'(Rx_Overflow), 0);
            if (i == 129) checkOutput("ovf_at_129", int'(Rx_Overflow), 1);
        end
        pushEvent(EV_EOF, 126, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drainCheck("ovf_drain");
        checkOutput("ovf_sticky", int'(Rx_Overflow), 1);
        ackAndCheck("ovf");

        $display("[TB] short frame and FCS error frame");
        sendFrame(2, 1'b0, 0, 1'b1);
        drainCheck("short_drain");
        ackAndCheck("short");
        sendFrame(6, 1'b1, 4, 1'b1);
        drainCheck("fcs_drain");
        ackAndCheck("fcs");

        $display("[TB] idle flags then abort in OPEN");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("open_abort_valid", int'(Rx_ValidFrame), 0);
        sendByte(1'b0);
        drainCheck("open_abort_drain");

        $display("[TB] byte coinciding with closing flag");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendByte(1'b1);
        pushEvent(EV_EOF, 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drainCheck("coincide_drain");
        ackAndCheck("coincide");

        $display("[TB] RxEN dropped mid-frame");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sendByte(1'b1);
        RxEN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rxen_valid_fall", int'(Rx_ValidFrame), 0);
        RxEN = 1'b1;
        drainCheck("rxen_drain");

        $display("[TB] traffic during HOLD, then reset in HOLD");
        sendFrame(4, 1'b0, 2, 1'b0);
        drainCheck("hold_frame_drain");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sendByte(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        RxEN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        RxEN = 1'b1;
        drainCheck("hold_traffic_drain");
        checkOutput("hold_ready_kept", int'(Rx_Ready), 1);
        checkOutput("hold_size_kept", int'(Rx_FrameSize), 2);
        checkOutput("hold_err_kept", int'(Rx_FrameError), 0);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("hold_reset_outputs",
                    int'({Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow,
                          Rx_EoF, Rx_Ready, Rx_FrameError}), 0);
        checkOutput("hold_reset_size", int'(Rx_FrameSize), 0);
        Rst = 1'b0;
        sendFrame(4, 1'b0, 2, 1'b0);
        drainCheck("post_reset_drain");
        ackAndCheck("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
